// File: rtl/fill_pipe_pkg.sv
// fill_pkg: shared types and constants for the fill_pipe block.
//   mode_t       : 3-bit per-beat transform selector
//   CNT_W        : width of the delivered-fill counter
//   mode_is_fill : 1 when a mode counts toward fill_cnt (anything not PASS-like)
// Optional feature macro: FILL_PIPE_XZ_EN (adds XFILL/ZFILL as counted fill modes).
package fill_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        MODE_PASS  = 3'd0,
        MODE_ZERO  = 3'd1,
        MODE_ONES  = 3'd2,
        MODE_CAST  = 3'd3,
        MODE_XFILL = 3'd4,
        MODE_ZFILL = 3'd5
    } mode_t;

    // Codes without a transform of their own behave as PASS and are not counted.
    function automatic logic mode_is_fill(input mode_t m);
        logic f;
        f = 1'b0;
        case (m)
            MODE_ZERO, MODE_ONES, MODE_CAST: f = 1'b1;
`ifdef FILL_PIPE_XZ_EN
            MODE_XFILL, MODE_ZFILL:          f = 1'b1;
`endif
            default:                         f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fill_pipe_stage.sv
// fill_pipe_stage: one pipeline register slot (valid + fill flag + data).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : this slot advances this cycle (takes upstream contents)
//   i_valid/i_fill/i_data : upstream slot contents (or the newly accepted beat)
//   o_valid/o_fill/o_data : registered contents of this slot
module fill_pipe_stage #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic             i_fill,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_fill,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic             r_fill;
    logic [WIDTH-1:0] r_data;

    // On load an empty upstream slot becomes a bubble here; payload is only
    // captured for real beats so bubbles do not toggle the data register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_fill  <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_fill <= i_fill;
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_fill  = r_fill;
    assign o_data  = r_data;

endmodule

// File: rtl/fill_pipe.sv
// fill_pipe: DEPTH-stage valid/ready register pipe that applies a per-beat
// fill transform (PASS/ZERO/ONES/CAST) on acceptance and counts delivered
// non-PASS beats in a saturating counter.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_mode : upstream beat and its transform
//   out_valid/out_ready/out_data  : downstream beat
//   fill_cnt                      : saturating count of delivered fill beats
// Optional feature macro: FILL_PIPE_XZ_EN (XFILL=4 -> all x, ZFILL=5 -> all z).
//
// Handshake: a beat transfers on any rising edge where valid && ready are both
// high; valid never depends on ready, and in_ready never depends on in_valid.
module fill_pipe
    import fill_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 2,
    parameter int CAST_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  mode_t            in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] fill_cnt
);

    // Reset release is taken through one flop so in_ready rises on the
    // first clock edge after rst_n goes high.
    logic r_run;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // Transform on the input side; the result is registered in stage 0.
    logic [WIDTH-1:0] w_xform_data;
    logic             w_xform_fill;
    always_comb begin
        w_xform_data = in_data;
        w_xform_fill = mode_is_fill(in_mode);
        case (in_mode)
            MODE_ZERO: w_xform_data = '0;
            MODE_ONES: w_xform_data = '1;
            MODE_CAST: begin
                w_xform_data             = '0;
                w_xform_data[CAST_W-1:0] = in_data[CAST_W-1:0];
            end
`ifdef FILL_PIPE_XZ_EN
            MODE_XFILL: w_xform_data = 'x;
            MODE_ZFILL: w_xform_data = 'z;
`endif
            default:   w_xform_data = in_data;
        endcase
    end

    logic [DEPTH-1:0]            w_sv;
    logic [DEPTH-1:0]            w_sf;
    logic [DEPTH-1:0][WIDTH-1:0] w_sd;
    logic [DEPTH-1:0]            w_take;
    logic [DEPTH-1:0]            w_up_valid;
    logic [DEPTH-1:0]            w_up_fill;
    logic [DEPTH-1:0][WIDTH-1:0] w_up_data;
    logic                        w_tail_full;
    logic                        w_acc;

    // Slot k may advance when some slot at or after k is empty or the sink
    // drains the last slot; this collapses bubbles anywhere in the pipe.
    always_comb begin
        w_take      = '0;
        w_tail_full = 1'b1;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_tail_full = w_tail_full & w_sv[k];
            w_take[k]   = out_ready | ~w_tail_full;
        end
    end

    assign in_ready = r_run & w_take[0];
    assign w_acc    = in_valid & in_ready;

    always_comb begin
        w_up_valid    = '0;
        w_up_fill     = '0;
        w_up_data     = '0;
        w_up_valid[0] = w_acc;
        w_up_fill[0]  = w_xform_fill;
        w_up_data[0]  = w_xform_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_up_valid[k] = w_sv[k-1];
            w_up_fill[k]  = w_sf[k-1];
            w_up_data[k]  = w_sd[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        fill_pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_load  (w_take[k]),
            .i_valid (w_up_valid[k]),
            .i_fill  (w_up_fill[k]),
            .i_data  (w_up_data[k]),
            .o_valid (w_sv[k]),
            .o_fill  (w_sf[k]),
            .o_data  (w_sd[k])
        );
    end

    assign out_valid = w_sv[DEPTH-1];
    assign out_data  = w_sd[DEPTH-1];

    logic [CNT_W-1:0] r_fill_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cnt <= '0;
        end else if (out_valid && out_ready && w_sf[DEPTH-1] && (r_fill_cnt != '1)) begin
            r_fill_cnt <= r_fill_cnt + CNT_W'(1);
        end
    end

    assign fill_cnt = r_fill_cnt;

endmodule

// File: doc/fill_pipe.md
FILL_PIPE -- requirements
Module: fill_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, meaning data path width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 2, meaning number of register stages (>=1).
REQ-003 The module SHALL have parameter CAST_W, default 3, meaning cast width for CAST mode (1..WIDTH).
REQ-004 The module SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The module SHALL have port in_valid, input, 1, meaning input beat present.
REQ-007 The module SHALL have port in_ready, output, 1, meaning the pipe accepts the beat this cycle.
REQ-008 The module SHALL have port in_data, input, WIDTH, meaning input payload.
REQ-009 The module SHALL have port in_mode, input, fill_pkg::mode_t (3 bits), meaning the transform applied to this beat.
REQ-010 The module SHALL have port out_valid, output, 1, meaning output beat present.
REQ-011 The module SHALL have port out_ready, input, 1, meaning the sink accepts the output beat.
REQ-012 The module SHALL have port out_data, output, WIDTH, meaning the transformed payload.
REQ-013 The module SHALL have port fill_cnt, output, 16, meaning the count of delivered beats whose mode was not PASS.

Function
REQ-014 Modes SHALL be PASS=0 (in_data), ZERO=1 (all 0), ONES=2 (all 1), CAST=3 (in_data[CAST_W-1:0] zero-extended to WIDTH); codes 4..7 SHALL behave as PASS.
REQ-015 The transform SHALL be applied on acceptance (in_valid && in_ready) and stored in stage 0, with no combinational path from in_data to out_data.
REQ-016 Each stage SHALL hold a valid bit plus WIDTH data bits, with beats advancing from stage k to stage k+1 when k+1 is empty or is itself advancing.
REQ-017 Beats SHALL be delivered from stage DEPTH-1 on out_valid && out_ready, in acceptance order, with none lost or duplicated.
REQ-018 Latency SHALL be exactly DEPTH cycles from acceptance to out_valid when the pipe is empty and out_ready=1.
REQ-019 in_ready SHALL be high when any stage is empty or out_ready=1, so that bubbles collapse and full throughput is 1 beat/cycle.
REQ-020 With all DEPTH stages full and out_ready=0, in_ready SHALL be 0 and all stage contents SHALL hold.
REQ-021 Acceptance and delivery in the same cycle while full SHALL keep occupancy unchanged.
REQ-022 fill_cnt SHALL increment by 1 on delivery of a non-PASS beat, SHALL saturate at 16'hFFFF, and SHALL never wrap.
REQ-023 The mode of a beat SHALL travel with that beat, so that mode changes mid-stream affect only later beats.

Reset
REQ-024 While rst_n=0, all valid bits, out_valid, in_ready, out_data and fill_cnt SHALL be 0 immediately, independent of clk.
REQ-025 Reset deassertion SHALL be synchronised internally, and in_ready SHALL rise on the first clk edge after release.
REQ-026 Reset mid-stream SHALL discard all in-flight beats, and no beat SHALL be delivered after release that was not accepted after release.

Configuration
REQ-027 When macro FILL_PIPE_XZ_EN is defined, mode XFILL=4 SHALL produce all-x and ZFILL=5 SHALL produce all-z for simulation, and both SHALL count in fill_cnt.
REQ-028 When FILL_PIPE_XZ_EN is undefined, codes 4 and 5 SHALL behave as PASS, and the synthesised netlist SHALL contain no x/z constants.

Structure
REQ-029 Package fill_pkg SHALL hold mode_t (enum, 3 bits), the mode constants, and CNT_W=16.
REQ-030 One sub-module, fill_pipe_stage (valid+data register with advance logic), SHALL be instantiated DEPTH times via generate.
REQ-031 The fill constants SHALL be written as unbased unsized literals so they scale with WIDTH.

Verification
REQ-032 The bench SHALL check reset: rst_n=0 asynchronously mid-cycle -> out_valid=0, fill_cnt=0, out_data=0 before the next edge.
REQ-033 The bench SHALL check modes: WIDTH=64, DEPTH=2, out_ready=1, beats PASS 64'h0123_4567_89AB_CDEF, ZERO, ONES, CAST 64'hFF -> out_data 64'h0123_4567_89AB_CDEF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7 at cycles 2,3,4,5; fill_cnt=3.
REQ-034 The bench SHALL check backpressure: DEPTH=2, out_ready=0, 3 beats offered -> 2 accepted, in_ready=0; then out_ready=1 -> all 3 delivered in order.
REQ-035 The bench SHALL check saturation: fill_cnt forced to 16'hFFFE, 3 ONES beats -> fill_cnt=16'hFFFF.
REQ-036 The bench SHALL check the macro: with FILL_PIPE_XZ_EN, modes 4 and 5 -> out_data === {64{1'bx}} and {64{1'bz}}; without it, in_data is passed through.
REQ-037 The bench SHALL check edge parameters: WIDTH=1, DEPTH=1, CAST_W=1, streaming random modes with random out_ready -> matches the reference model, with no drop or duplication.
